l15_mem_responder: RTL and testbench

// - L1.5-side responder for the core<->L1.5 memory request interface (req: rqtype/size/address/data/val; resp: data_0/1, returntype, val).
// - Accepts one load or store at a time and backs it with a parameterised 64-bit-word memory.
// - Returns load lines or store acks after a fixed latency.
// - Serves as the bench/simulation partner for the core memory stage and as the on-chip scratch memory for bring-up.

---
 rtl/l15_pkg.sv | 30 +++
 rtl/l15_byte_mask.sv | 36 +++
 rtl/l15_mem_responder.sv | 133 +++++++++++++
 tb/tb_l15_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/l15_pkg.sv
// Shared encodings and request payload for the core<->L1.5 memory interface.
package l15_pkg;

  localparam logic [4:0] RQ_LOAD      = 5'b00000;
  localparam logic [4:0] RQ_STORE     = 5'b00001;

  localparam logic [3:0] RT_LOAD      = 4'b0000;
  localparam logic [3:0] RT_STORE_ACK = 4'b0100;
  localparam logic [3:0] RT_ERR       = 4'b1110;

  localparam logic [2:0] SZ_1B        = 3'b000;
  localparam logic [2:0] SZ_2B        = 3'b001;
  localparam logic [2:0] SZ_4B        = 3'b010;
  localparam logic [2:0] SZ_8B        = 3'b011;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] address;
    logic [63:0] data;
  } req_t;

  // log2 of the access size in bytes; any size with bit 2 set is a full word
  function automatic logic [1:0] size_log2(input logic [2:0] size);
    return size[2] ? 2'd3 : size[1:0];
  endfunction

endpackage

// File: rtl/l15_byte_mask.sv
// Byte-lane mask for a store and merge of the new lanes into the old word.
module l15_byte_mask
  import l15_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] old_word,
  input  logic [63:0] new_word,
  output logic [7:0]  mask_c,
  output logic [63:0] merged_c
);

  logic [1:0] lg;
  logic [2:0] off;
  logic [3:0] nbytes;

  // Misaligned offsets are aligned down to the access size.
  always_comb begin
    lg     = size_log2(size);
    off    = addr_lo & 3'(3'b111 << lg);
    nbytes = 4'(4'd1 << lg);
    mask_c = '0;
    for (int k = 0; k < 8; k++) begin
      mask_c[k] = (k >= int'(off)) && (k < int'(off) + int'(nbytes));
    end
  end

  // Byte k lives in bits [63-8k -: 8] (big-endian lanes).
  always_comb begin
    merged_c = old_word;
    for (int k = 0; k < 8; k++) begin
      if (mask_c[k]) merged_c[63-8*k -: 8] = new_word[63-8*k -: 8];
    end
  end

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5-side responder: one load/store at a time, backed by a 64-bit-word memory.
module l15_mem_responder
  import l15_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  core_l15_rqtype,
  input  logic [2:0]  core_l15_size,
  input  logic [31:0] core_l15_address,
  input  logic [63:0] core_l15_data,
  input  logic        core_l15_val,
  input  logic        core_l15_req_ack,
  output logic        l15_core_header_ack,
  output logic        l15_core_ack,
  output logic        l15_core_val,
  output logic [3:0]  l15_core_returntype,
  output logic [63:0] l15_core_data_0,
  output logic [63:0] l15_core_data_1,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [63:0] bd_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  req_t          req_q;
  logic [63:0]   mem [DEPTH];

  logic          accept_c, commit_c;
  logic [AW-1:0] word_idx, line_idx0, line_idx1, bd_idx;
  logic [7:0]    store_mask;
  logic [63:0]   store_word;
  logic          unused_bits;

  assign word_idx  = req_q.address[3 +: AW];
  assign line_idx0 = {word_idx[AW-1:1], 1'b0};
  assign line_idx1 = {word_idx[AW-1:1], 1'b1};
  assign bd_idx    = bd_addr[3 +: AW];
  assign unused_bits = ^{req_q.address[31:3+AW], bd_addr[31:3+AW], bd_addr[2:0], store_mask};

  l15_byte_mask u_byte_mask (
    .size     (req_q.size),
    .addr_lo  (req_q.address[2:0]),
    .old_word (mem[word_idx]),
    .new_word (req_q.data),
    .mask_c   (store_mask),
    .merged_c (store_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_l15_val) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (core_l15_req_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept strobe (combinational handshake) and commit strobe
  always_comb begin
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state)
      IDLE:    accept_c = core_l15_val & ~rst;
      WAIT:    commit_c = (cnt == '0);
      default: ;
    endcase
  end

  assign l15_core_header_ack = accept_c;
  assign l15_core_ack        = accept_c;

  // Latch the request on accept and count down the wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      req_q <= '0;
    end else if (accept_c) begin
      cnt   <= CW'(LATENCY - 1);
      req_q <= '{rqtype: core_l15_rqtype, size: core_l15_size,
                 address: core_l15_address, data: core_l15_data};
    end else if (state == WAIT && cnt != '0) begin
      cnt   <= cnt - CW'(1);
    end
  end

  // Response registers: loaded on commit, held through RESP, cleared on req_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l15_core_val        <= 1'b0;
      l15_core_returntype <= '0;
      l15_core_data_0     <= '0;
      l15_core_data_1     <= '0;
    end else if (commit_c) begin
      l15_core_val <= 1'b1;
      if (req_q.rqtype == RQ_LOAD) begin
        l15_core_returntype <= RT_LOAD;
        l15_core_data_0     <= mem[line_idx0];
        l15_core_data_1     <= mem[line_idx1];
      end else begin
        l15_core_returntype <= (req_q.rqtype == RQ_STORE) ? RT_STORE_ACK : RT_ERR;
        l15_core_data_0     <= '0;
        l15_core_data_1     <= '0;
      end
    end else if (state == RESP && core_l15_req_ack) begin
      l15_core_val        <= 1'b0;
      l15_core_returntype <= '0;
      l15_core_data_0     <= '0;
      l15_core_data_1     <= '0;
    end
  end

  // Memory: not reset; a store commit overrides a same-cycle backdoor write
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_wdata;
    if (commit_c && req_q.rqtype == RQ_STORE) mem[word_idx] <= store_word;
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
// Self-checking bench: transaction-level model of memory and response timing.
module tb_l15_mem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned AW      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  core_l15_rqtype = '0;
  logic [2:0]  core_l15_size = '0;
  logic [31:0] core_l15_address = '0;
  logic [63:0] core_l15_data = '0;
  logic        core_l15_val = 1'b0;
  logic        core_l15_req_ack = 1'b0;
  logic        l15_core_header_ack, l15_core_ack, l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [63:0] l15_core_data_0, l15_core_data_1;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [63:0] bd_wdata = '0;

  l15_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .core_l15_rqtype     (core_l15_rqtype),
    .core_l15_size       (core_l15_size),
    .core_l15_address    (core_l15_address),
    .core_l15_data       (core_l15_data),
    .core_l15_val        (core_l15_val),
    .core_l15_req_ack    (core_l15_req_ack),
    .l15_core_header_ack (l15_core_header_ack),
    .l15_core_ack        (l15_core_ack),
    .l15_core_val        (l15_core_val),
    .l15_core_returntype (l15_core_returntype),
    .l15_core_data_0     (l15_core_data_0),
    .l15_core_data_1     (l15_core_data_1),
    .bd_we               (bd_we),
    .bd_addr             (bd_addr),
    .bd_wdata            (bd_wdata)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nerr = 0;
  logic        cmp_en = 1'b1;

  // Expected DUT outputs for the current cycle
  logic        exp_hack = 1'b0;
  logic        exp_val = 1'b0;
  logic [3:0]  exp_rt = '0;
  logic [63:0] exp_d0 = '0;
  logic [63:0] exp_d1 = '0;

  logic [63:0] mdl [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all outputs against the expectation
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("header_ack", 64'(l15_core_header_ack), 64'(exp_hack));
      chk("ack",        64'(l15_core_ack),        64'(exp_hack));
      chk("val",        64'(l15_core_val),        64'(exp_val));
      chk("returntype", 64'(l15_core_returntype), 64'(exp_rt));
      chk("data_0",     l15_core_data_0,          exp_d0);
      chk("data_1",     l15_core_data_1,          exp_d1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return AW'((a / 8) % DEPTH);
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [31:0] a);
    return AW'(((a / 16) * 2) % DEPTH);
  endfunction

  // Store rule: n-byte access, offset aligned down to n, byte k = bits [63-8k -: 8]
  function automatic logic [63:0] mdl_store(input logic [63:0] old_w, input logic [63:0] new_w,
                                            input logic [2:0] sz, input logic [2:0] lo);
    int n, off;
    logic [63:0] r;
    n   = (sz >= 3'd3) ? 8 : (1 << int'(sz));
    off = int'(lo) - (int'(lo) % n);
    r   = old_w;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + n) r[63-8*b -: 8] = new_w[63-8*b -: 8];
    return r;
  endfunction

  task automatic bd_write(input logic [AW-1:0] w, input logic [63:0] d);
    bd_we = 1'b1; bd_addr = 32'(w) * 8; bd_wdata = d;
    mdl[w] = d;
    step();
    bd_we = 1'b0;
  endtask

  // One full transaction: request, wait, response held 'hold' cycles, ack.
  task automatic txn(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                     input logic [63:0] d, input int hold, input bit poke, input bit bdc,
                     output logic [3:0] got_rt, output logic [63:0] got_d0, output logic [63:0] got_d1);
    logic [AW-1:0] wi, l0;
    logic [3:0]    r_rt;
    logic [63:0]   r_d0, r_d1, bdv;
    wi = word_of(a);
    l0 = line_of(a);
    r_d0 = '0; r_d1 = '0;
    bdv = {$urandom, $urandom};
    if (rq == 5'd0) begin
      r_rt = 4'b0000; r_d0 = mdl[l0]; r_d1 = mdl[l0 + AW'(1)];
    end else if (rq == 5'd1) begin
      r_rt = 4'b0100; mdl[wi] = mdl_store(mdl[wi], d, sz, a[2:0]);
    end else begin
      r_rt = 4'b1110;
    end
    if (bdc && rq != 5'd1) mdl[wi] = bdv;
    core_l15_rqtype = rq; core_l15_size = sz; core_l15_address = a; core_l15_data = d;
    core_l15_val = 1'b1; exp_hack = 1'b1;
    step();
    core_l15_val = 1'b0; exp_hack = 1'b0;
    repeat (LATENCY - 1) step();
    if (bdc) begin bd_we = 1'b1; bd_addr = {a[31:3], 3'b000}; bd_wdata = bdv; end
    step();
    bd_we = 1'b0;
    exp_val = 1'b1; exp_rt = r_rt; exp_d0 = r_d0; exp_d1 = r_d1;
    got_rt = l15_core_returntype; got_d0 = l15_core_data_0; got_d1 = l15_core_data_1;
    if (poke) core_l15_val = 1'b1;
    core_l15_req_ack = 1'b0;
    repeat (hold) step();
    core_l15_req_ack = 1'b1;
    step();
    core_l15_req_ack = 1'b0; core_l15_val = 1'b0;
    exp_val = 1'b0; exp_rt = '0; exp_d0 = '0; exp_d1 = '0;
  endtask

  // Reset asserted in the first WAIT cycle: request dropped, no response
  task automatic reset_mid(input logic [4:0] rq, input logic [31:0] a, input logic [63:0] d);
    core_l15_rqtype = rq; core_l15_size = 3'd3; core_l15_address = a; core_l15_data = d;
    core_l15_val = 1'b1; exp_hack = 1'b1;
    step();
    core_l15_val = 1'b0; exp_hack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_val", 64'(l15_core_val), 64'd0);
    step();
    rst = 1'b0;
    repeat (LATENCY + 3) step();
  endtask

  initial begin
    logic [3:0]  rt;
    logic [63:0] d0, d1;
    logic [4:0]  rq;
    logic [31:0] a;
    int          r;

    repeat (3) step();
    chk("reset_val", 64'(l15_core_val), 64'd0);
    chk("reset_rt", 64'(l15_core_returntype), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < int'(DEPTH); i++) bd_write(AW'(i), {$urandom, $urandom});
    bd_write(AW'(0), 64'h0011223344556677);
    bd_write(AW'(1), 64'h8899AABBCCDDEEFF);

    txn(5'd0, 3'd3, 32'h0, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("load0_rt", 64'(rt), 64'h0);
    chk("load0_d0", d0, 64'h0011223344556677);
    chk("load0_d1", d1, 64'h8899AABBCCDDEEFF);

    txn(5'd1, 3'd2, 32'h4, {2{32'hDEADBEEF}}, 1, 1'b0, 1'b0, rt, d0, d1);
    chk("store4_rt", 64'(rt), 64'h4);
    chk("mdl_pin_store4", mdl[0], 64'h00112233DEADBEEF);
    txn(5'd0, 3'd3, 32'h0, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("store4_d0", d0, 64'h00112233DEADBEEF);

    bd_write(AW'(0), 64'h0011223344556677);
    txn(5'd1, 3'd0, 32'h3, {8{8'hA5}}, 0, 1'b0, 1'b0, rt, d0, d1);
    txn(5'd0, 3'd3, 32'h8, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("store1_d0", d0, 64'h001122A544556677);

    txn(5'd1, 3'd1, 32'h5, 64'h0102030405060708, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("mdl_pin_store2", mdl[0], 64'h001122A505066677);
    txn(5'd0, 3'd3, 32'h0, 64'h0, 5, 1'b1, 1'b0, rt, d0, d1);
    chk("store2_d0", d0, 64'h001122A505066677);

    txn(5'b00101, 3'd3, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 1'b0, rt, d0, d1);
    chk("err_rt", 64'(rt), 64'hE);
    chk("err_d0", d0, 64'h0);
    txn(5'd0, 3'd3, 32'h0, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("err_mem_kept", d0, 64'h001122A505066677);

    reset_mid(5'd0, 32'h0, 64'h0);
    reset_mid(5'd1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    txn(5'd0, 3'd3, 32'h0, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);
    chk("after_rst_d0", d0, 64'h001122A505066677);
    chk("after_rst_d1", d1, 64'h8899AABBCCDDEEFF);

    // Backdoor collisions: store wins, load sees pre-write value
    txn(5'd1, 3'd3, 32'h10, 64'h1111_2222_3333_4444, 0, 1'b0, 1'b1, rt, d0, d1);
    txn(5'd0, 3'd3, 32'h18, 64'h0, 0, 1'b0, 1'b1, rt, d0, d1);
    chk("bd_store_wins", d0, 64'h1111_2222_3333_4444);
    txn(5'd0, 3'd3, 32'h18, 64'h0, 0, 1'b0, 1'b0, rt, d0, d1);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      rq = 5'd0;
      else if (r < 9) rq = 5'd1;
      else            rq = 5'($urandom_range(2, 31));
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      txn(rq, 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rt, d0, d1);
    end

    repeat (3) step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
